// File: rtl/uart_tx_mmio_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - register offsets inside the 8-byte window
//   - STATUS bit positions and the STATUS value seen while in reset
//   - transmitter FSM state encoding (2 bits)
//   - packStatus(): assembles the STATUS word from its fields
// ---------------------------------------------------------------------------
package uart_tx_mmio_pkg;

  // Register offsets; only bit 2 distinguishes them, bits [1:0] are ignored
  localparam logic [2:0] OFFSET_TXDATA = 3'h0;
  localparam logic [2:0] OFFSET_STATUS = 3'h4;

  // STATUS bit positions
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 2;
  localparam int STATUS_OVF_BIT   = 3;
  localparam int STATUS_COUNT_LSB = 8;

  // Empty FIFO, idle transmitter, no overflow
  localparam logic [31:0] STATUS_RESET_VALUE = 32'h0000_0002;

  // Transmitter FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Builds the STATUS word; every bit not named here reads as zero
  function automatic logic [31:0] packStatus(input logic       full,
                                             input logic       empty,
                                             input logic       busy,
                                             input logic       overflow,
                                             input logic [7:0] count);
    logic [31:0] status;
    status                            = '0;
    status[STATUS_FULL_BIT]           = full;
    status[STATUS_EMPTY_BIT]          = empty;
    status[STATUS_BUSY_BIT]           = busy;
    status[STATUS_OVF_BIT]            = overflow;
    status[STATUS_COUNT_LSB +: 8]     = count;
    return status;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered pointers and occupancy count.
// Read data is the current head entry (show-ahead), valid whenever not empty.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-low reset (empties the FIFO)
//   i_push    write request; ignored when full (a same-cycle pop does not help)
//   i_wdata   data written on an accepted push
//   i_pop     read request; ignored when empty
//   o_rdata   head entry
//   o_full    count == DEPTH
//   o_empty   count == 0
//   o_count   number of stored entries
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int             AW         = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  // Full is judged on the registered count, so a pop in the same cycle
  // cannot make room for a push that arrives while full.
  assign o_full   = (r_count == FULL_COUNT);
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_rdata  = r_mem[r_rdPtr];
  assign w_doPush = reset && i_push && !o_full;
  assign w_doPop  = reset && i_pop && !o_empty;

  // Pointer and count bookkeeping; pointers wrap naturally since DEPTH is a
  // power of two. A simultaneous push and pop leaves the count untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because empty hides them
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio
// Memory-mapped 8N1 UART transmitter with a TX FIFO.
// Register window (8 bytes at BASE_ADDR):
//   +0x0 TXDATA  write: queue byte [7:0]; reads 0
//   +0x4 STATUS  [0] full [1] empty [2] busy [3] overflow (sticky,
//                cleared by any write here) [15:8] fifo count
// Ports:
//   clk             rising-edge clock
//   reset           synchronous active-low reset
//   mem_address_in  byte address of the processor access
//   mem_wdata_in    store data
//   mem_wstrobe_in  single-cycle write strobe
//   mem_rdata_out   combinational read data (STATUS or 0)
//   sel_out         combinational window decode
//   tx_out          serial output, idle high
// ---------------------------------------------------------------------------
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_address_in,
  input  logic [31:0] mem_wdata_in,
  input  logic        mem_wstrobe_in,
  output logic [31:0] mem_rdata_out,
  output logic        sel_out,
  output logic        tx_out
);

  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [1:0]                    r_state;
  logic [15:0]                   r_baudCnt;
  logic [2:0]                    r_bitIdx;
  logic [7:0]                    r_shift;
  logic                          r_tx;
  logic                          r_overflow;

  logic                          w_isTxData;
  logic                          w_isStatus;
  logic                          w_pushReq;
  logic                          w_clearReq;
  logic                          w_pop;
  logic                          w_busy;
  logic [7:0]                    w_fifoData;
  logic                          w_fifoFull;
  logic                          w_fifoEmpty;
  logic [$clog2(FIFO_DEPTH):0]   w_fifoCount;
  logic [31:0]                   w_status;
  logic                          w_unusedBits;

  // Address decode: bits [1:0] are don't-care, bit 2 picks the register
  assign sel_out    = (mem_address_in[31:3] == BASE_ADDR[31:3]);
  assign w_isTxData = sel_out && (mem_address_in[2] == OFFSET_TXDATA[2]);
  assign w_isStatus = sel_out && (mem_address_in[2] == OFFSET_STATUS[2]);
  assign w_pushReq  = reset && mem_wstrobe_in && w_isTxData;
  assign w_clearReq = reset && mem_wstrobe_in && w_isStatus;
  assign w_busy     = (r_state != ST_IDLE);

  // IDLE takes the head byte as soon as the FIFO shows it; no bypass path
  assign w_pop      = (r_state == ST_IDLE) && !w_fifoEmpty;

  // Only the low byte of store data and the word offset are meaningful
  assign w_unusedBits = ^{mem_wdata_in[31:8], mem_address_in[1:0]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_pushReq),
    .i_wdata (mem_wdata_in[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifoData),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty),
    .o_count (w_fifoCount)
  );

  // While reset is held low the registers may not have been cleared yet,
  // so STATUS reports the reset value directly.
  assign w_status = reset ? packStatus(w_fifoFull, w_fifoEmpty, w_busy,
                                       r_overflow, 8'(w_fifoCount))
                          : STATUS_RESET_VALUE;

  assign mem_rdata_out = w_isStatus ? w_status : 32'h0;
  assign tx_out        = r_tx;

  // Sticky overflow flag: a dropped push wins over a clear in the same cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_pushReq && w_fifoFull) begin
      r_overflow <= 1'b1;
    end else if (w_clearReq) begin
      r_overflow <= 1'b0;
    end
  end

  // Transmitter FSM. The baud counter is reloaded on every state or bit
  // transition and counts down to zero, so each bit spans CLKS_PER_BIT
  // cycles. The line level is registered alongside the state so tx_out
  // changes exactly on the transition edge. After STOP the FSM spends one
  // cycle in IDLE before popping the next byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_baudCnt <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (!w_fifoEmpty) begin
            r_shift   <= w_fifoData;
            r_baudCnt <= BAUD_RELOAD;
            r_tx      <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (r_baudCnt == '0) begin
            r_baudCnt <= BAUD_RELOAD;
            r_bitIdx  <= '0;
            r_tx      <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_baudCnt <= r_baudCnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (r_baudCnt == '0) begin
            r_baudCnt <= BAUD_RELOAD;
            if (r_bitIdx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 1'b1;
              r_shift  <= r_shift >> 1;
              r_tx     <= r_shift[1];
            end
          end else begin
            r_baudCnt <= r_baudCnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (r_baudCnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_baudCnt <= r_baudCnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
